// File: rtl/thermal_event_handler_pkg.sv
// Shared constants for the thermal event handler slice.
// Holds the socket / memory-VR counts, the thermal_cause bit positions and
// the FSM state encodings.
// Optional feature macro used elsewhere in the slice: THERMAL_ALERT_THROTTLE_EN.
package thermal_event_handler_pkg;

    localparam int unsigned NUM_CPU   = 2;
    localparam int unsigned NUM_MEMVR = 4;

    // thermal_cause bit positions
    localparam int unsigned CAUSE_W           = 4;
    localparam int unsigned CAUSE_CPU_TRIP    = 0;
    localparam int unsigned CAUSE_SENSOR_TRIP = 1;
    localparam int unsigned CAUSE_VR_HOT      = 2;
    localparam int unsigned CAUSE_MEM_ALERT   = 3;

    // FSM state encodings
    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_ARM_WAIT = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_SHUTDOWN = 3'd3;
    localparam logic [2:0] ST_LOCKOUT  = 3'd4;

endpackage

// File: rtl/thermal_event_handler_if.sv
// Signal bundle between the thermal qualifier / sequencer / BMC side (master)
// and the thermal event handler (slave).
// Inputs to the handler: t1ms, st_steady_pwrok, or_all_cpu_thermtrip,
//   sensor_thermtrip, qual_cpu_vr_hot_n, qual_mem_vr_hot_n,
//   qual_cpu_ab_alert, qual_cpu_cd_alert, bmc_clr.
// Outputs from the handler: thermtrip_ena, thermal_shutdown_req, pwr_lockout,
//   cpu_prochot_n, thermal_cause, thermal_irq_n.
// Used with or without THERMAL_ALERT_THROTTLE_EN; the bundle is identical.
interface thermal_event_handler_if #(
    parameter int unsigned NUM_CPU   = thermal_event_handler_pkg::NUM_CPU,
    parameter int unsigned NUM_MEMVR = thermal_event_handler_pkg::NUM_MEMVR
);
    logic                 t1ms;
    logic                 st_steady_pwrok;
    logic                 or_all_cpu_thermtrip;
    logic                 sensor_thermtrip;
    logic [NUM_CPU-1:0]   qual_cpu_vr_hot_n;
    logic [NUM_MEMVR-1:0] qual_mem_vr_hot_n;
    logic [NUM_CPU-1:0]   qual_cpu_ab_alert;
    logic [NUM_CPU-1:0]   qual_cpu_cd_alert;
    logic                 bmc_clr;

    logic                 thermtrip_ena;
    logic                 thermal_shutdown_req;
    logic                 pwr_lockout;
    logic [NUM_CPU-1:0]   cpu_prochot_n;
    logic [3:0]           thermal_cause;
    logic                 thermal_irq_n;

    modport master (
        output t1ms, st_steady_pwrok, or_all_cpu_thermtrip, sensor_thermtrip,
               qual_cpu_vr_hot_n, qual_mem_vr_hot_n, qual_cpu_ab_alert,
               qual_cpu_cd_alert, bmc_clr,
        input  thermtrip_ena, thermal_shutdown_req, pwr_lockout,
               cpu_prochot_n, thermal_cause, thermal_irq_n
    );

    modport slave (
        input  t1ms, st_steady_pwrok, or_all_cpu_thermtrip, sensor_thermtrip,
               qual_cpu_vr_hot_n, qual_mem_vr_hot_n, qual_cpu_ab_alert,
               qual_cpu_cd_alert, bmc_clr,
        output thermtrip_ena, thermal_shutdown_req, pwr_lockout,
               cpu_prochot_n, thermal_cause, thermal_irq_n
    );

endinterface

// File: rtl/thermal_event_handler_hot_stretch.sv
// One PROCHOT# channel: asserts prochot_n low while src is high and keeps it
// low for HOT_STRETCH_MS ms ticks after src releases.
// Ports: clk, rst_n (async active-low), src (throttle source), t1ms (1 ms
//   tick), clear (forces release and clears the count), prochot_n (out).
// Not affected by THERMAL_ALERT_THROTTLE_EN; the top decides what feeds src.
module thermal_event_handler_hot_stretch #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned HOT_STRETCH_MS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic t1ms,
    input  logic clear,
    output logic prochot_n
);

    logic             active;
    logic             src_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            src_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            src_q <= src;
            if (clear) begin
                active <= 1'b0;
                cnt    <= '0;
            end else if (src) begin
                active <= 1'b1;
                cnt    <= '0;
            end else if (active) begin
                if (cnt == CNT_W'(HOT_STRETCH_MS)) begin
                    active <= 1'b0;
                    cnt    <= '0;
                end else if (t1ms && !src_q) begin
                    // a tick coinciding with the source falling edge is dropped
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign prochot_n = ~active;

endmodule

// File: rtl/thermal_event_handler.sv
// Thermal event handler: arms thermtrip after steady power good, requests
// shutdown on a qualified thermtrip, locks out power-on until the BMC clears,
// drives stretched per-CPU PROCHOT# and keeps sticky cause bits + BMC irq.
// Ports: clk, pgd_p3v3_stby_async (async active-low reset), bus (slave side
//   of thermal_event_handler_if carrying all qualifier/BMC signals).
// Macro THERMAL_ALERT_THROTTLE_EN: when defined, memory alerts also drive
//   PROCHOT# (and hence the VR-hot cause); otherwise alerts only set cause[3].
module thermal_event_handler
    import thermal_event_handler_pkg::*;
#(
    parameter int unsigned NUM_CPU        = thermal_event_handler_pkg::NUM_CPU,
    parameter int unsigned NUM_MEMVR      = thermal_event_handler_pkg::NUM_MEMVR,
    parameter int unsigned ARM_DLY_MS     = 10,
    parameter int unsigned HOT_STRETCH_MS = 5,
    parameter int unsigned CNT_W          = 8
) (
    input logic                   clk,
    input logic                   pgd_p3v3_stby_async,
    thermal_event_handler_if.slave bus
);

    localparam int unsigned G = NUM_MEMVR / NUM_CPU;

    logic [2:0]         state, state_nx;
    logic [CNT_W-1:0]   arm_cnt, arm_cnt_nx;
    logic [NUM_CPU-1:0] src;
    logic [NUM_CPU-1:0] alert;
    logic [NUM_CPU-1:0] prochot_n;
    logic [CAUSE_W-1:0] cause, cause_set, cause_active, cause_nx;
    logic               trip;
    logic               trip_window;
    logic               hot_window;

    assign trip = bus.or_all_cpu_thermtrip | bus.sensor_thermtrip;

    for (genvar i = 0; i < NUM_CPU; i++) begin : g_cpu
        assign alert[i] = bus.qual_cpu_ab_alert[i] | bus.qual_cpu_cd_alert[i];
`ifdef THERMAL_ALERT_THROTTLE_EN
        assign src[i] = ~bus.qual_cpu_vr_hot_n[i] | ~&bus.qual_mem_vr_hot_n[i*G +: G]
                      | alert[i];
`else
        assign src[i] = ~bus.qual_cpu_vr_hot_n[i] | ~&bus.qual_mem_vr_hot_n[i*G +: G];
`endif

        thermal_event_handler_hot_stretch #(
            .CNT_W          (CNT_W),
            .HOT_STRETCH_MS (HOT_STRETCH_MS)
        ) u_hot_stretch (
            .clk       (clk),
            .rst_n     (pgd_p3v3_stby_async),
            .src       (src[i]),
            .t1ms      (bus.t1ms),
            .clear     (state == ST_DISARMED),
            .prochot_n (prochot_n[i])
        );
    end

    assign bus.cpu_prochot_n = prochot_n;

    always_comb begin
        state_nx   = state;
        arm_cnt_nx = arm_cnt;
        case (state)
            ST_DISARMED: begin
                arm_cnt_nx = '0;
                if (bus.st_steady_pwrok) state_nx = ST_ARM_WAIT;
            end
            ST_ARM_WAIT: begin
                if (!bus.st_steady_pwrok)                   state_nx = ST_DISARMED;
                else if (arm_cnt == CNT_W'(ARM_DLY_MS))     state_nx = ST_ARMED;
                else if (bus.t1ms)                          arm_cnt_nx = arm_cnt + 1'b1;
            end
            ST_ARMED: begin
                // thermtrip has priority over a simultaneous pwrok loss
                if (trip)                       state_nx = ST_SHUTDOWN;
                else if (!bus.st_steady_pwrok)  state_nx = ST_DISARMED;
            end
            ST_SHUTDOWN: begin
                if (!bus.st_steady_pwrok) state_nx = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (bus.bmc_clr) state_nx = ST_DISARMED;
            end
            default: state_nx = ST_DISARMED;
        endcase
    end

    always_comb begin
        trip_window = (state == ST_ARMED) || (state == ST_SHUTDOWN);
        hot_window  = trip_window || (state == ST_ARM_WAIT);

        cause_set                    = '0;
        cause_set[CAUSE_CPU_TRIP]    = trip_window & bus.or_all_cpu_thermtrip;
        cause_set[CAUSE_SENSOR_TRIP] = trip_window & bus.sensor_thermtrip;
        cause_set[CAUSE_VR_HOT]      = hot_window & (|src);
        cause_set[CAUSE_MEM_ALERT]   = |alert;

        cause_active                    = '0;
        cause_active[CAUSE_CPU_TRIP]    = bus.or_all_cpu_thermtrip;
        cause_active[CAUSE_SENSOR_TRIP] = bus.sensor_thermtrip;
        cause_active[CAUSE_VR_HOT]      = |src;
        cause_active[CAUSE_MEM_ALERT]   = |alert;

        // clear only bits whose source is idle; a new set always wins
        cause_nx = (cause & ~({CAUSE_W{bus.bmc_clr}} & ~cause_active)) | cause_set;
    end

    always_ff @(posedge clk or negedge pgd_p3v3_stby_async) begin
        if (!pgd_p3v3_stby_async) begin
            state                    <= ST_DISARMED;
            arm_cnt                  <= '0;
            cause                    <= '0;
            bus.thermtrip_ena        <= 1'b0;
            bus.thermal_shutdown_req <= 1'b0;
            bus.pwr_lockout          <= 1'b0;
            bus.thermal_irq_n        <= 1'b1;
        end else begin
            state                    <= state_nx;
            arm_cnt                  <= arm_cnt_nx;
            cause                    <= cause_nx;
            bus.thermtrip_ena        <= (state_nx == ST_ARMED) || (state_nx == ST_SHUTDOWN);
            bus.thermal_shutdown_req <= (state_nx == ST_SHUTDOWN);
            bus.pwr_lockout          <= (state_nx == ST_LOCKOUT);
            bus.thermal_irq_n        <= ~|cause_nx;
        end
    end

    assign bus.thermal_cause = cause;

endmodule
